// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with HI/LO result registers.
// It sits beside the single-cycle ALU in the execute stage. The pipeline stalls
// while busy is high and reads hi/lo for MFHI/MFLO.
//
// Ports:
//   clk       rising-edge clock
//   rstn      asynchronous active-low reset
//   start     operation request, sampled on the clock edge
//   op        000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   a         multiplicand / dividend / MTHI-MTLO data
//   b         multiplier / divisor
//   busy      iterative operation in progress
//   done      one-cycle pulse: new mul/div result visible on hi/lo
//   div_zero  last DIV/DIVU had b==0; held until the next mul/div start
//   hi        HI register (product upper half / remainder)
//   lo        LO register (product lower half / quotient)
//
// Timing: the start-sampling edge loads the operands and enters StCalc. StCalc
// runs WIDTH iterations followed by one turnaround cycle, then StFix applies the
// sign correction. done rises WIDTH+2 edges after the start edge.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned AccW = 2 * WIDTH + 1;
  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e state_q, state_d;

  logic [AccW-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;     // multiplicand (mul) or divisor (div)
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d; // negate product / quotient
  logic             neg_rem_q, neg_rem_d; // negate remainder (dividend sign)
  logic             b_zero_q, b_zero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;

  // Operand conditioning
  logic             signed_op, a_neg, b_neg, muldiv_req;
  logic [WIDTH-1:0] mag_a, mag_b;

  always_comb begin
    signed_op  = ~op[0];
    muldiv_req = ~op[2];
    a_neg      = signed_op & a[WIDTH-1];
    b_neg      = signed_op & b[WIDTH-1];
    mag_a      = a_neg ? -a : a;
    mag_b      = b_neg ? -b : b;
  end

  // One iteration of shift-add multiply and restoring divide
  logic [WIDTH:0]   mul_sum;
  logic [AccW-1:0]  mul_next;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] div_diff;
  logic [AccW-1:0]  div_next;

  always_comb begin
    // Top accumulator bit is always zero here, so the W+1-bit sum cannot overflow.
    mul_sum  = acc_q[0] ? (acc_q[AccW-1:WIDTH] + {1'b0, opnd_q}) : acc_q[AccW-1:WIDTH];
    mul_next = {1'b0, mul_sum, acc_q[WIDTH-1:1]};
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff = {1'b0, rem_sh} - {2'b00, opnd_q};
    if (div_diff[WIDTH+1]) begin
      div_next = {rem_sh, acc_q[WIDTH-2:0], 1'b0};
    end else begin
      div_next = {div_diff[WIDTH:0], acc_q[WIDTH-2:0], 1'b1};
    end
  end

  // Sign correction applied in StFix
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    prod_fix = neg_res_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
    quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    // With b==0 the remainder is |a|; re-applying a's sign restores raw a.
    rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  // Next-state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start && muldiv_req) state_d = StCalc;
      StCalc: if (cnt_q == CntLast) state_d = StFix;
      StFix:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state
  always_comb begin
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    b_zero_d   = b_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (muldiv_req) begin
            is_div_d   = op[1];
            acc_d      = {{(WIDTH + 1){1'b0}}, (op[1] ? mag_a : mag_b)};
            opnd_d     = op[1] ? mag_b : mag_a;
            cnt_d      = '0;
            neg_res_d  = a_neg ^ b_neg;
            neg_rem_d  = a_neg;
            b_zero_d   = (b == '0);
            div_zero_d = 1'b0;
          end else if (op == 3'b100) begin
            hi_d = a;
          end else if (op == 3'b101) begin
            lo_d = a;
          end
        end
      end
      StCalc: begin
        if (cnt_q != CntLast) begin
          acc_d = is_div_q ? div_next : mul_next;
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StFix: begin
        done_d = 1'b1;
        if (is_div_q) begin
          lo_d       = b_zero_q ? '1 : quo_fix;
          hi_d       = rem_fix;
          div_zero_d = b_zero_q;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q      <= '0;
      opnd_q     <= '0;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      b_zero_q   <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      b_zero_q   <= b_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32) with hand-computed expected values.
module tb_muldiv_unit;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  // Per-operation observations gathered by run_op
  int          r_edge;
  int          r_dcnt;
  int          r_bcnt;
  logic        r_dz_done;
  logic        r_dz_first;
  logic [31:0] r_hi_mid;
  logic [31:0] r_lo_mid;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op and observe 40 cycles. Sample k=0 is the cycle after the start edge.
  // inj_k >= 0 pulses a second start (MULT 3*3) at that sample; rst_k >= 0 drops rstn.
  task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input int inj_k, input int rst_k);
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    @(negedge clk);
    start = 1'b0;
    r_edge = -1; r_dcnt = 0; r_bcnt = 0; r_dz_done = 1'bx;
    r_dz_first = div_zero;
    r_hi_mid = '0; r_lo_mid = '0;
    for (int k = 0; k < 40; k++) begin
      if (busy === 1'b1) r_bcnt++;
      if (done === 1'b1) begin
        r_dcnt++;
        if (r_edge < 0) begin
          r_edge = k;
          r_dz_done = div_zero;
        end
      end
      if (k == 10) begin
        r_hi_mid = hi;
        r_lo_mid = lo;
      end
      if (k == inj_k) begin
        start = 1'b1; op = 3'b000; a = 32'd3; b = 32'd3;
      end
      if (k == inj_k + 1) start = 1'b0;
      if (k == rst_k) rstn = 1'b0;
      if (k == rst_k + 2) rstn = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++;
    if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_dz: got %b want 0", div_zero); end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult();
    run_op(3'b000, 32'hFFFFFFFD, 32'h00000005, -1, -1);
    checks++; if (r_edge != 34) begin errors++; $display("FAIL mult_latency: got %0d want 34", r_edge); end
    checks++; if (r_bcnt != 34) begin errors++; $display("FAIL mult_busy_cycles: got %0d want 34", r_bcnt); end
    checks++; if (r_dcnt != 1) begin errors++; $display("FAIL mult_done_pulses: got %0d want 1", r_dcnt); end
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
    checks++; if (lo !== 32'hFFFFFFF1) begin errors++; $display("FAIL mult_lo: got %h want fffffff1", lo); end
  endtask

  task automatic test_multu();
    run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, -1);
    checks++;
    if (r_hi_mid !== 32'hFFFFFFFF) begin errors++; $display("FAIL multu_hold_hi: got %h want ffffffff", r_hi_mid); end
    checks++;
    if (r_lo_mid !== 32'hFFFFFFF1) begin errors++; $display("FAIL multu_hold_lo: got %h want fffffff1", r_lo_mid); end
    checks++; if (hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
    checks++; if (lo !== 32'h00000001) begin errors++; $display("FAIL multu_lo: got %h want 00000001", lo); end
  endtask

  task automatic test_mthi_mtlo();
    @(negedge clk);
    start = 1'b1; op = 3'b100; a = 32'h12345678;
    @(negedge clk);
    start = 1'b0;
    checks++; if (hi !== 32'h12345678) begin errors++; $display("FAIL mthi_hi: got %h want 12345678", hi); end
    checks++; if (lo !== 32'h00000001) begin errors++; $display("FAIL mthi_lo: got %h want 00000001", lo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy: got %b want 0", busy); end
    start = 1'b1; op = 3'b101; a = 32'hCAFEF00D;
    @(negedge clk);
    start = 1'b0;
    checks++; if (lo !== 32'hCAFEF00D) begin errors++; $display("FAIL mtlo_lo: got %h want cafef00d", lo); end
    checks++; if (hi !== 32'h12345678) begin errors++; $display("FAIL mtlo_hi: got %h want 12345678", hi); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mtlo_done: got %b want 0", done); end
  endtask

  task automatic test_undefined_op();
    @(negedge clk);
    start = 1'b1; op = 3'b110; a = 32'h0; b = 32'h0;
    @(negedge clk);
    op = 3'b111;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL undef_busy: got %b want 0", busy); end
    checks++; if (hi !== 32'h12345678) begin errors++; $display("FAIL undef_hi: got %h want 12345678", hi); end
    checks++; if (lo !== 32'hCAFEF00D) begin errors++; $display("FAIL undef_lo: got %h want cafef00d", lo); end
  endtask

  task automatic test_div();
    run_op(3'b010, 32'hFFFFFFF9, 32'h00000002, -1, -1);
    checks++; if (r_edge != 34) begin errors++; $display("FAIL div_latency: got %0d want 34", r_edge); end
    checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo: got %h want fffffffd", lo); end
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi: got %h want ffffffff", hi); end
    checks++; if (r_dz_done !== 1'b0) begin errors++; $display("FAIL div_dz: got %b want 0", r_dz_done); end
    run_op(3'b010, 32'h00000007, 32'hFFFFFFFE, -1, -1);
    checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_negb_lo: got %h want fffffffd", lo); end
    checks++; if (hi !== 32'h00000001) begin errors++; $display("FAIL div_negb_hi: got %h want 00000001", hi); end
    run_op(3'b011, 32'd100, 32'd7, -1, -1);
    checks++; if (lo !== 32'd14) begin errors++; $display("FAIL divu_lo: got %h want 0000000e", lo); end
    checks++; if (hi !== 32'd2) begin errors++; $display("FAIL divu_hi: got %h want 00000002", hi); end
  endtask

  task automatic test_div_min();
    run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, -1, -1);
    checks++; if (lo !== 32'h80000000) begin errors++; $display("FAIL divmin_lo: got %h want 80000000", lo); end
    checks++; if (hi !== 32'h00000000) begin errors++; $display("FAIL divmin_hi: got %h want 00000000", hi); end
  endtask

  task automatic test_div_zero();
    run_op(3'b011, 32'h00000007, 32'h00000000, -1, -1);
    checks++; if (r_edge != 34) begin errors++; $display("FAIL dz_latency: got %0d want 34", r_edge); end
    checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL dz_lo: got %h want ffffffff", lo); end
    checks++; if (hi !== 32'h00000007) begin errors++; $display("FAIL dz_hi: got %h want 00000007", hi); end
    checks++; if (r_dz_done !== 1'b1) begin errors++; $display("FAIL dz_with_done: got %b want 1", r_dz_done); end
    checks++; if (div_zero !== 1'b1) begin errors++; $display("FAIL dz_held: got %b want 1", div_zero); end
    run_op(3'b010, 32'hFFFFFFF9, 32'h00000000, -1, -1);
    checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL dzs_lo: got %h want ffffffff", lo); end
    checks++; if (hi !== 32'hFFFFFFF9) begin errors++; $display("FAIL dzs_hi: got %h want fffffff9", hi); end
    checks++; if (div_zero !== 1'b1) begin errors++; $display("FAIL dzs_flag: got %b want 1", div_zero); end
    run_op(3'b000, 32'd6, 32'd7, -1, -1);
    checks++; if (r_dz_first !== 1'b0) begin errors++; $display("FAIL dz_clear: got %b want 0", r_dz_first); end
    checks++; if (lo !== 32'd42) begin errors++; $display("FAIL dz_next_lo: got %h want 0000002a", lo); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL dz_next_hi: got %h want 00000000", hi); end
  endtask

  task automatic test_start_while_busy();
    run_op(3'b010, 32'hFFFFFFF9, 32'h00000002, 5, -1);
    checks++; if (r_dcnt != 1) begin errors++; $display("FAIL busy_start_pulses: got %0d want 1", r_dcnt); end
    checks++; if (r_edge != 34) begin errors++; $display("FAIL busy_start_latency: got %0d want 34", r_edge); end
    checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL busy_start_lo: got %h want fffffffd", lo); end
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL busy_start_hi: got %h want ffffffff", hi); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_idle: got %b want 0", busy); end
  endtask

  task automatic test_reset_midop();
    run_op(3'b000, 32'd3, 32'd4, -1, 10);
    checks++; if (r_dcnt != 0) begin errors++; $display("FAIL rst_mid_done: got %0d want 0", r_dcnt); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL rst_mid_hi: got %h want 0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL rst_mid_lo: got %h want 0", lo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    run_op(3'b001, 32'h00010000, 32'h00010000, -1, -1);
    checks++; if (r_edge != 34) begin errors++; $display("FAIL rst_after_latency: got %0d want 34", r_edge); end
    checks++; if (hi !== 32'h00000001) begin errors++; $display("FAIL rst_after_hi: got %h want 00000001", hi); end
    checks++; if (lo !== 32'h00000000) begin errors++; $display("FAIL rst_after_lo: got %h want 00000000", lo); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_mthi_mtlo();
    test_undefined_op();
    test_div();
    test_div_min();
    test_div_zero();
    test_start_while_busy();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
